irfan_tinysnn: RTL and testbench



---
 rtl/irfan_tinysnn_if.sv | 26 ++
 rtl/irfan_tinysnn.sv | 104 ++++++++++
 tb/tb_irfan_tinysnn.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irfan_tinysnn_if.sv
// irfan_tinysnn_if: Tiny Tapeout pin harness bundle (spike inputs, control
// inputs, outputs and output enables) for the irfan_tinysnn tile.
// master: the harness/driver side. slave: the SNN tile.
interface irfan_tinysnn_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/irfan_tinysnn.sv
// irfan_tinysnn: four leaky integrate-and-fire neurons, each fully connected
// to eight binary spike inputs through signed 4-bit weights. Weights,
// threshold and leak come from a 138-bit serial chain loaded MSB-first.
// Optional build macro: TINYSNN_LEAK_EN (when undefined the neurons are pure
// integrate-and-fire; the leak bits are still part of the chain).
module irfan_tinysnn (
  input logic            clk,
  input logic            rst_n,
  input logic            ena,
  irfan_tinysnn_if.slave bus
);

  // chain layout: [137:136] leak, [135:128] threshold, [127:0] weights
  localparam logic [137:0] CFG_RESET = {2'd1, 8'd16, 128'd0};

  logic [137:0]      cfg;
  logic signed [7:0] v [4];
  logic [3:0]        spk;

  logic              cfg_en;
  logic              cfg_data;
  logic              step;
  logic [1:0]        mon_sel;
  logic signed [7:0] thr;
  logic [7:0]        mon_v;
  logic              unused_bits;

  logic [3:0]        w_nib;
  logic signed [9:0] sum       [4];
  logic signed [7:0] leak_term [4];
  logic signed [9:0] t_raw     [4];
  logic signed [7:0] t_sat     [4];
  logic signed [7:0] v_nxt     [4];
  logic [3:0]        spk_nxt;

  assign cfg_en   = bus.uio_in[0];
  assign cfg_data = bus.uio_in[1];
  assign step     = bus.uio_in[2];
  assign mon_sel  = bus.uio_in[4:3];
  assign thr      = cfg[135:128];

`ifdef TINYSNN_LEAK_EN
  logic [1:0] leak;
  assign leak        = cfg[137:136];
  assign unused_bits = &{1'b0, bus.uio_in[7:5]};
`else
  assign unused_bits = &{1'b0, cfg[137:136], bus.uio_in[7:5]};
`endif

  // next membrane and spike for every neuron, evaluated for the coming step
  always_comb begin
    spk_nxt = '0;
    w_nib   = '0;
    for (int n = 0; n < 4; n++) begin
      sum[n] = '0;
      for (int i = 0; i < 8; i++) begin
        w_nib = cfg[4*(8*n+i) +: 4];
        if (bus.ui_in[i]) sum[n] = sum[n] + {{6{w_nib[3]}}, w_nib};
      end
`ifdef TINYSNN_LEAK_EN
      // shift by zero would remove the whole membrane, so leak=0 means none
      leak_term[n] = (leak == 2'd0) ? 8'sd0 : (v[n] >>> leak);
`else
      leak_term[n] = 8'sd0;
`endif
      t_raw[n] = {{2{v[n][7]}}, v[n]} - {{2{leak_term[n][7]}}, leak_term[n]} + sum[n];
      if (t_raw[n] > 10'sd127)       t_sat[n] = 8'sd127;
      else if (t_raw[n] < -10'sd128) t_sat[n] = -8'sd128;
      else                           t_sat[n] = t_raw[n][7:0];
      if (t_sat[n] >= thr) begin
        spk_nxt[n] = 1'b1;
        v_nxt[n]   = 8'sd0;
      end else begin
        v_nxt[n]   = t_sat[n];
      end
    end
  end

  // config shift has priority over step; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= CFG_RESET;
      spk <= '0;
      for (int n = 0; n < 4; n++) v[n] <= 8'sd0;
    end else if (ena) begin
      if (cfg_en) begin
        cfg <= {cfg[136:0], cfg_data};
      end else if (step) begin
        spk <= spk_nxt;
        for (int n = 0; n < 4; n++) v[n] <= v_nxt[n];
      end
    end
  end

  // monitor nibble is read straight from the selected membrane register
  always_comb begin
    mon_v = v[mon_sel];
  end

  assign bus.uo_out  = {mon_v[7:4], spk};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_irfan_tinysnn.sv
// tb_irfan_tinysnn: randomized stimulus against an integer-arithmetic model
// of the four LIF neurons, plus directed scenarios with literal expectations.
module tb_irfan_tinysnn;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;

  irfan_tinysnn_if bus ();

  irfan_tinysnn dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state
  bit [137:0] shadow;
  int mw [4][8];
  int mthr;
  int mleak;
  int mv [4];
  bit [3:0] mspk;
  bit [1:0] msel;

  // config to load
  int cw [4][8];
  int cthr;
  int cleak;

  function automatic int sx(input int val, input int bits);
    int half;
    half = 1 << (bits - 1);
    return (val >= half) ? val - (1 << bits) : val;
  endfunction

  function automatic void decode();
    bit [3:0] nib;
    bit [7:0] tb8;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 8; i++) begin
        nib = shadow[4*(8*n+i) +: 4];
        mw[n][i] = sx(int'(nib), 4);
      end
    tb8   = shadow[135:128];
    mthr  = sx(int'(tb8), 8);
    mleak = int'(shadow[137:136]);
  endfunction

  function automatic void model_reset();
    shadow = '0;
    shadow[135:128] = 8'd16;
    shadow[137:136] = 2'd1;
    decode();
    for (int n = 0; n < 4; n++) mv[n] = 0;
    mspk = '0;
  endfunction

  function automatic int floor_div_pow2(input int val, input int k);
    int d;
    d = 1 << k;
    if (val >= 0) return val / d;
    return -((-val + d - 1) / d);
  endfunction

  function automatic void model_step(input bit [7:0] x);
    int s, lt, t;
    for (int n = 0; n < 4; n++) begin
      s = 0;
      for (int i = 0; i < 8; i++) if (x[i]) s += mw[n][i];
      lt = 0;
`ifdef TINYSNN_LEAK_EN
      if (mleak != 0) lt = floor_div_pow2(mv[n], mleak);
`endif
      t = mv[n] - lt + s;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      if (t >= mthr) begin
        mspk[n] = 1'b1;
        mv[n]   = 0;
      end else begin
        mspk[n] = 1'b0;
        mv[n]   = t;
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [7:0] vb;
    logic [7:0] e;
    if (chk_en) begin
      vb = 8'(mv[msel]);
      e  = {vb[7:4], mspk};
      checks++;
      if (bus.uo_out !== e) begin
        errors++;
        $display("FAIL uo_out @%0t: got %h expected %h", $time, bus.uo_out, e);
      end
      checks++;
      if ({bus.uio_out, bus.uio_oe} !== 16'h0000) begin
        errors++;
        $display("FAIL uio_out/uio_oe @%0t: got %h/%h expected 00/00", $time, bus.uio_out, bus.uio_oe);
      end
    end
  end

  task automatic tick(input bit e, input bit ce, input bit cd, input bit st,
                      input bit [7:0] x, input bit [1:0] sel);
    ena        = e;
    bus.ui_in  = x;
    bus.uio_in = {3'($urandom), sel, st, cd, ce};
    msel       = sel;
    @(posedge clk);
    #1;
    if (e) begin
      if (ce) begin
        shadow = {shadow[136:0], cd};
        decode();
      end else if (st) begin
        model_step(x);
      end
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset uo_out", int'(bus.uo_out), 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic clear_cw();
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 8; i++) cw[n][i] = 0;
  endtask

  task automatic load_cfg();
    bit [137:0] vec;
    vec = '0;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 8; i++) vec[4*(8*n+i) +: 4] = 4'(cw[n][i]);
    vec[135:128] = 8'(cthr);
    vec[137:136] = 2'(cleak);
    for (int b = 137; b >= 0; b--) begin
      if ($urandom_range(9) == 0)
        tick(1'b0, 1'b1, 1'($urandom), 1'b1, 8'($urandom), msel);
      tick(1'b1, 1'b1, vec[b], 1'($urandom), 8'($urandom), msel);
    end
  endtask

  int exp_v [5];
  int exp_nib [5];

  initial begin
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    msel       = 2'd0;
    model_reset();
    #12;
    chk("por uo_out", int'(bus.uo_out), 0);
    chk("por uio_out", int'(bus.uio_out), 0);
    chk("por uio_oe", int'(bus.uio_oe), 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // zero weights: no spikes
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 2'd0);
    chk("zero-weight step uo_out", int'(bus.uo_out), 0);

    // threshold fire on neuron 0
    do_reset();
    clear_cw();
    cw[0][0] = 7; cw[0][1] = 7; cthr = 16; cleak = 0;
    msel = 2'd0;
    load_cfg();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 2'd0);
    chk("fire step1 model V0", mv[0], 14);
    chk("fire step1 uo_out", int'(bus.uo_out), 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 2'd0);
    chk("fire step2 model V0", mv[0], 0);
    chk("fire step2 uo_out", int'(bus.uo_out), 8'h01);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0);
    chk("fire step3 uo_out", int'(bus.uo_out), 8'h00);

    // leak on neuron 1
    do_reset();
    clear_cw();
    cw[1][0] = 7; cthr = 127; cleak = 1;
    msel = 2'd1;
    load_cfg();
`ifdef TINYSNN_LEAK_EN
    exp_v = '{7, 11, 13, 14, 14};
    exp_nib = '{0, 0, 0, 0, 0};
`else
    exp_v = '{7, 14, 21, 28, 35};
    exp_nib = '{0, 0, 1, 1, 2};
`endif
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'd1);
      chk($sformatf("leak step%0d model V1", k), mv[1], exp_v[k]);
      chk($sformatf("leak step%0d monitor", k), int'(bus.uo_out[7:4]), exp_nib[k]);
    end

    // hold: cfg_en with step, then ena low with step
    tick(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 2'd1);
    chk("hold cfg_en model V1", mv[1], exp_v[4]);
    chk("hold cfg_en monitor", int'(bus.uo_out[7:4]), exp_nib[4]);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 2'd1);
    chk("hold ena model V1", mv[1], exp_v[4]);
    chk("hold ena monitor", int'(bus.uo_out[7:4]), exp_nib[4]);
    do_reset();
    chk("post-reset model thr", mthr, 16);
    chk("post-reset uo_out", int'(bus.uo_out), 0);

    // negative saturation on neuron 2
    clear_cw();
    for (int i = 0; i < 8; i++) cw[2][i] = -8;
    cthr = 16; cleak = 0;
    msel = 2'd2;
    load_cfg();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 2'd2);
    chk("sat step1 model V2", mv[2], -64);
    chk("sat step1 uo_out", int'(bus.uo_out), 8'hC0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 2'd2);
    chk("sat step2 model V2", mv[2], -128);
    chk("sat step2 uo_out", int'(bus.uo_out), 8'h80);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 2'd2);
    chk("sat step3 uo_out", int'(bus.uo_out), 8'h80);

    // randomized rounds
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int n = 0; n < 4; n++)
        for (int i = 0; i < 8; i++) cw[n][i] = int'($urandom_range(15)) - 8;
      cthr  = int'($urandom_range(100)) - 30;
      cleak = int'($urandom_range(3));
      msel  = 2'($urandom);
      load_cfg();
      for (int k = 0; k < 200; k++) begin
        int p;
        p = int'($urandom_range(99));
        if (p < 70)
          tick(1'b1, 1'b0, 1'b0, 1'b1, 8'($urandom), 2'($urandom));
        else if (p < 78)
          tick(1'b1, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom));
        else if (p < 88)
          tick(1'b0, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 2'($urandom));
        else if (p < 99)
          tick(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 2'($urandom));
        else
          do_reset();
      end
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
